// File: rtl/fu_issue_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fu_issue_pkg
// Description : Shared constants for the functional-unit issue controller.
//               Holds the default lane geometry, the opcode width shared with
//               FpuBasic/FpuMultDiv, the tag width, the outstanding-op depth
//               and the statistics counter width.
// Revision    : 1.0 - initial release
// ============================================================================
package fu_issue_pkg;

  localparam int C_LANE_W = 32;  // bits per lane
  localparam int C_LANES  = 4;   // lanes per operand/result bus
  localparam int C_OPW    = 6;   // opcode width, common to all FP/int units
  localparam int C_TW     = 5;   // tag width (opaque destination id)
  localparam int C_DEPTH  = 8;   // max outstanding operations, power of two
  localparam int C_STAT_W = 32;  // statistics counter width

endpackage : fu_issue_pkg
`default_nettype wire

// File: rtl/fu_tag_fifo.sv
`default_nettype none
// ============================================================================
// Module      : fu_tag_fifo
// Description : W x DEPTH synchronous FIFO holding issue tags in order.
//               Pointers carry one extra wrap bit so full and empty are
//               distinguished without a separate counter.
// Ports       : i_clk    clock (rising edge)
//               i_rst    asynchronous active-high reset (pointers to 0)
//               i_push   write i_din at the tail (ignored when full)
//               i_din    tag to write
//               i_pop    advance the head (ignored when empty)
//               o_head   tag at the head
//               o_full   DEPTH entries held
//               o_empty  no entries held
//               o_count  number of entries held
// Revision    : 1.0 - initial release
// ============================================================================
module fu_tag_fifo #(
  parameter int W     = 5,
  parameter int DEPTH = 8
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_push,
  input  logic [W-1:0]             i_din,
  input  logic                     i_pop,
  output logic [W-1:0]             o_head,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] r_mem [DEPTH];
  logic [AW:0]  r_wptr;
  logic [AW:0]  r_rptr;
  logic [AW:0]  w_count;
  logic         w_do_push;
  logic         w_do_pop;

  assign w_count   = r_wptr - r_rptr;
  assign o_count   = w_count;
  assign o_full    = (w_count == (AW+1)'(DEPTH));
  assign o_empty   = (r_wptr == r_rptr);
  assign o_head    = r_mem[r_rptr[AW-1:0]];

  // Protect the pointers against a misbehaving caller.
  assign w_do_push = i_push & ~o_full;
  assign w_do_pop  = i_pop & ~o_empty;

  // Storage needs no reset: an entry is only read after it has been written.
  always_ff @(posedge i_clk) begin
    if (w_do_push) begin
      r_mem[r_wptr[AW-1:0]] <= i_din;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_do_push) begin
        r_wptr <= r_wptr + 1'b1;
      end
      if (w_do_pop) begin
        r_rptr <= r_rptr + 1'b1;
      end
    end
  end

endmodule : fu_tag_fifo
`default_nettype wire

// File: rtl/fu_issue_ctl.sv
`default_nettype none
// ============================================================================
// Module      : fu_issue_ctl
// Description : Core-side initiator for a long-latency functional unit.
//               Forwards accepted requests straight to the unit, tracks
//               outstanding tags in issue order and returns each in-order
//               result with its tag through a one-entry registered buffer
//               with back-pressure. A full buffer that writeback is not
//               taking stalls both issue and the unit pipeline.
// Ports       : phi/rst                       clock, async active-high reset
//               req_valid/ready/opcode/a/b/tag  request from issue stage
//               unit_valid/opcode/a/b/stall     to the functional unit
//               unit_finish/unit_res            from the functional unit
//               wb_valid/ready/tag/res          result to writeback
//               err                             sticky spurious-finish flag
//               busy                            work outstanding or buffered
// Option      : FU_ISSUE_STATS_EN adds saturating counters stat_issued,
//               stat_done and stat_stall.
// Revision    : 1.0 - initial release
// ============================================================================
module fu_issue_ctl
  import fu_issue_pkg::*;
#(
  parameter int N     = C_LANE_W,
  parameter int L     = C_LANES,
  parameter int OPW   = C_OPW,
  parameter int TW    = C_TW,
  parameter int DEPTH = C_DEPTH
) (
  input  logic               phi,
  input  logic               rst,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [OPW-1:0]     req_opcode,
  input  logic [N*L-1:0]     req_a,
  input  logic [N*L-1:0]     req_b,
  input  logic [TW-1:0]      req_tag,
  output logic               unit_valid,
  output logic [OPW-1:0]     unit_opcode,
  output logic [N*L-1:0]     unit_a,
  output logic [N*L-1:0]     unit_b,
  output logic               unit_stall,
  input  logic               unit_finish,
  input  logic [N*L-1:0]     unit_res,
  output logic               wb_valid,
  input  logic               wb_ready,
  output logic [TW-1:0]      wb_tag,
  output logic [N*L-1:0]     wb_res,
  output logic               err,
  output logic               busy
`ifdef FU_ISSUE_STATS_EN
  ,
  output logic [C_STAT_W-1:0] stat_issued,
  output logic [C_STAT_W-1:0] stat_done,
  output logic [C_STAT_W-1:0] stat_stall
`endif
);

  localparam int AW = $clog2(DEPTH);

  logic               w_stall;
  logic               w_issue;
  logic               w_finish_ok;
  logic               w_capture;
  logic               w_spurious;
  logic               w_fifo_full;
  logic               w_fifo_empty;
  logic [TW-1:0]      w_head_tag;
  logic [AW:0]        w_fifo_count;

  logic               r_wb_full;
  logic [TW-1:0]      r_wb_tag;
  logic [N*L-1:0]     r_wb_res;
  logic               r_err;

  // A held result that writeback is not taking freezes everything upstream.
  assign w_stall     = r_wb_full & ~wb_ready;
  // Full ignores a same-cycle pop so occupancy can never exceed DEPTH.
  assign req_ready   = ~w_stall & ~w_fifo_full;
  assign w_issue     = req_valid & req_ready;

  assign unit_valid  = w_issue;
  assign unit_opcode = req_opcode;
  assign unit_a      = req_a;
  assign unit_b      = req_b;
  assign unit_stall  = w_stall;

  // The unit completes in order, so every accepted finish belongs to the head.
  assign w_finish_ok = unit_finish & ~w_stall;
  assign w_capture   = w_finish_ok & ~w_fifo_empty;
  assign w_spurious  = w_finish_ok & w_fifo_empty;

  fu_tag_fifo #(
    .W     (TW),
    .DEPTH (DEPTH)
  ) u_tag_fifo (
    .i_clk   (phi),
    .i_rst   (rst),
    .i_push  (w_issue),
    .i_din   (req_tag),
    .i_pop   (w_capture),
    .o_head  (w_head_tag),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty),
    .o_count (w_fifo_count)
  );

  // Capture takes priority over drain: a drain and capture in the same cycle
  // reloads the buffer and keeps it full, giving one result per cycle.
  always_ff @(posedge phi or posedge rst) begin
    if (rst) begin
      r_wb_full <= 1'b0;
      r_wb_tag  <= '0;
      r_wb_res  <= '0;
    end else if (w_capture) begin
      r_wb_full <= 1'b1;
      r_wb_tag  <= w_head_tag;
      r_wb_res  <= unit_res;
    end else if (r_wb_full && wb_ready) begin
      r_wb_full <= 1'b0;
    end
  end

  always_ff @(posedge phi or posedge rst) begin
    if (rst) begin
      r_err <= 1'b0;
    end else if (w_spurious) begin
      r_err <= 1'b1;
    end
  end

  assign wb_valid = r_wb_full;
  assign wb_tag   = r_wb_tag;
  assign wb_res   = r_wb_res;
  assign err      = r_err;
  assign busy     = (w_fifo_count != '0) | r_wb_full;

`ifdef FU_ISSUE_STATS_EN
  logic [C_STAT_W-1:0] r_stat_issued;
  logic [C_STAT_W-1:0] r_stat_done;
  logic [C_STAT_W-1:0] r_stat_stall;

  // All three counters saturate at all-ones rather than wrapping.
  always_ff @(posedge phi or posedge rst) begin
    if (rst) begin
      r_stat_issued <= '0;
      r_stat_done   <= '0;
      r_stat_stall  <= '0;
    end else begin
      if (w_issue && (r_stat_issued != '1)) begin
        r_stat_issued <= r_stat_issued + 1'b1;
      end
      if (w_capture && (r_stat_done != '1)) begin
        r_stat_done <= r_stat_done + 1'b1;
      end
      if (w_stall && (r_stat_stall != '1)) begin
        r_stat_stall <= r_stat_stall + 1'b1;
      end
    end
  end

  assign stat_issued = r_stat_issued;
  assign stat_done   = r_stat_done;
  assign stat_stall  = r_stat_stall;
`endif

endmodule : fu_issue_ctl
`default_nettype wire

// File: doc/fu_issue_ctl.md
# fu_issue_ctl

Core-side initiator for the functional-unit request/finish interface shared by the FP basic, FP mult/div and integer divide units. Accepts operations from the harmonica issue stage, drives the unit's valid/opcode/A/B/stall inputs, and tracks outstanding tags in order. Returns each result with its tag to the writeback stage through a registered, back-pressured port. One instance sits in front of each long-latency unit.

## Interface
- N, 32, lane width in bits
- L, 4, lane count; operand and result buses are N*L bits
- OPW, 6, opcode width
- TW, 5, tag width (destination register + warp/lane id, opaque here)
- DEPTH, 8, max outstanding operations; power of two, at least 2

- phi  in  1  clock; all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- req_valid  in  1  core offers an operation
- req_ready  out  1  operation accepted this cycle when req_valid is also high
- req_opcode  in  OPW  operation code
- req_a, req_b  in  N*L  operands
- req_tag  in  TW  tag returned with the result
- unit_valid  out  1  to unit Valid
- unit_opcode  out  OPW  to unit Opcode
- unit_a, unit_b  out  N*L  to unit A/B
- unit_stall  out  1  to unit Stall; unit freezes its pipeline and holds Finish/Res
- unit_finish  in  1  from unit Finish
- unit_res  in  N*L  from unit Res
- wb_valid  out  1  result buffer holds a result
- wb_ready  in  1  writeback consumes the result when wb_valid is also high
- wb_tag  out  TW  tag of the buffered result
- wb_res  out  N*L  buffered result
- err  out  1  sticky: unit_finish seen with no outstanding tag
- busy  out  1  outstanding count nonzero or wb_valid

## Operation
- Tag FIFO (DEPTH entries, read/write pointers of log2(DEPTH)+1 bits, wrap-around at DEPTH) holds tags in issue order. The unit completes in order.
- Result buffer: one entry {tag, res}, with a full flag.
- unit_stall = wb_full & ~wb_ready (combinational).
- req_ready = ~unit_stall & ~fifo_full. The full check ignores a same-cycle pop, so the FIFO never reaches DEPTH+1 entries.
- Issue (req_valid & req_ready): unit_valid = 1. unit_opcode/a/b driven combinationally from req_*, and push req_tag. When not issuing, unit_valid = 0 and operand outputs are don't-care; the bench checks them only under unit_valid.
- Capture (unit_finish & ~unit_stall):
  - FIFO nonempty: pop the head tag, load the buffer with {head tag, unit_res}, set wb_full.
  - FIFO empty: drop the result, set err, leave the buffer unchanged.
- Drain (wb_valid & wb_ready) with no capture in the same cycle: clear wb_full.
- Drain and capture in the same cycle: the buffer reloads and wb_full stays 1. This sustains full throughput of 1 result per cycle.
- Push and pop in the same cycle: both take effect and the count is unchanged.
- err clears only on rst.

## Timing
- Request to unit: 0 cycles; unit_valid is high in the accept cycle.
- unit_finish to wb_valid: 1 cycle, when captured.
- Issue throughput: 1 per cycle while not full and not stalled.
- Stall path: wb_full & ~wb_ready gives unit_stall in the same cycle. While stalled, no issue and no capture; unit Finish/Res are held by the unit.
- Reset values: req_ready 1, unit_valid 0, unit_stall 0, wb_valid 0, wb_tag 0, wb_res 0, err 0, busy 0; FIFO pointers 0.
- Reset mid-operation:
  - All outstanding tags and the buffered result are discarded.
  - Any unit_finish after reset for an operation issued before reset sets err. Software must reset the units together with this block.

## Configuration
- FU_ISSUE_STATS_EN defined: adds outputs stat_issued, stat_done, stat_stall (32 bits each).
  - stat_issued increments on each issue; stat_done on each capture; stat_stall on each cycle with unit_stall high.
  - All saturate at all-ones and reset to 0.
- Undefined: these ports and counters do not exist; the rest of the behaviour is identical.

## Structure
- Package fu_issue_pkg holds: default N/L/OPW/TW/DEPTH constants; opcode width constant shared with FpuBasic/FpuMultDiv; the stat counter width.
- Sub-module fu_tag_fifo: parameterised TW × DEPTH synchronous FIFO with push, pop, head, full, empty and count, and asynchronous reset. The controller logic stays in fu_issue_ctl.

## Test plan
- Single op: issue opcode 6'h01, tag 5'd3; unit finishes 4 cycles later with res 128'hA5…; wb_ready=1 -> wb_valid exactly 1 cycle after finish, wb_tag=3, wb_res matches, busy falls the cycle after drain.
- Fill: 8 back-to-back issues (tags 0..7) with the unit never finishing -> req_ready low from cycle 9 onward. A 9th request is held, and no push occurs.
- Backpressure: wb_ready=0 with a result buffered and unit_finish high -> unit_stall=1, req_ready=0, no pop. Raising wb_ready -> the buffered result drains and the next result is captured in the same cycle.
- Streaming: DEPTH issues with results returned 1 per cycle and wb_ready=1 -> tags emerge 0..7 in order with no bubbles, and pointers wrap correctly across 3 passes.
- Spurious finish: unit_finish with the FIFO empty -> err=1, wb_valid stays 0, err persists until rst.
- Reset mid-flight: 3 ops outstanding, assert rst -> all outputs reach reset values asynchronously. A later unit_finish sets err. With FU_ISSUE_STATS_EN, the counters read 0 after reset and stat_stall matches the counted stall cycles.
